// File: rtl/reg_status_file_mp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_status_file_mp_pkg
//  Brief    : Shared default widths for the multi-port register status file.
//  Revision : 1.0 - initial release
// ============================================================================
package reg_status_file_mp_pkg;

    localparam int C_XLEN      = 32;
    localparam int C_REG_WIDTH = 5;
    localparam int C_REG_SIZE  = 2 ** C_REG_WIDTH;
    localparam int C_ROB_WIDTH = 4;

endpackage
`default_nettype wire

// File: rtl/reg_read_port.sv
`default_nettype none
// ============================================================================
//  Module   : reg_read_port
//  Brief    : Priority resolution for one source operand read port.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_read_port
    import reg_status_file_mp_pkg::*;
#(
    parameter int XLEN      = C_XLEN,
    parameter int REG_WIDTH = C_REG_WIDTH,
    parameter int ROB_WIDTH = C_ROB_WIDTH
) (
    input  logic [REG_WIDTH-1:0] i_reg_id,
    input  logic [XLEN-1:0]      i_reg_data,
    input  logic                 i_reg_pending,
    input  logic [ROB_WIDTH-1:0] i_reg_dep,
    input  logic                 i_byp_hit,
    input  logic [XLEN-1:0]      i_byp_data,
    input  logic                 i_rob_ready,
    input  logic [XLEN-1:0]      i_rob_data,
    output logic [XLEN-1:0]      o_rd_data,
    output logic                 o_rd_pending,
    output logic [ROB_WIDTH-1:0] o_rd_dependency
);

    always_comb begin
        o_rd_data       = '0;
        o_rd_pending    = 1'b0;
        o_rd_dependency = '0;
        if (i_reg_id != '0) begin
            if (i_byp_hit) begin
                o_rd_data = i_byp_data;
            end else if (i_reg_pending && i_rob_ready) begin
                o_rd_data = i_rob_data;
            end else if (i_reg_pending) begin
                o_rd_pending    = 1'b1;
                o_rd_dependency = i_reg_dep;
            end else begin
                o_rd_data = i_reg_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_status_file_mp.sv
`default_nettype none
// ============================================================================
//  Module   : reg_status_file_mp
//  Brief    : Architectural register file with rename status, multi-commit
//             and multi-read ports with ROB forwarding and commit bypass.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_status_file_mp
    import reg_status_file_mp_pkg::*;
#(
    parameter int XLEN       = C_XLEN,
    parameter int REG_WIDTH  = C_REG_WIDTH,
    parameter int ROB_WIDTH  = C_ROB_WIDTH,
    parameter int NUM_READ   = 2,
    parameter int NUM_COMMIT = 2
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic                            flush,
    input  logic [NUM_COMMIT-1:0]           commit_en,
    input  logic [NUM_COMMIT*REG_WIDTH-1:0] commit_reg_id,
    input  logic [NUM_COMMIT*XLEN-1:0]      commit_data,
    input  logic [NUM_COMMIT*ROB_WIDTH-1:0] commit_rob_id,
    input  logic                            issue_en,
    input  logic [REG_WIDTH-1:0]            issue_reg_id,
    input  logic [ROB_WIDTH-1:0]            issue_rob_id,
    input  logic [NUM_READ*REG_WIDTH-1:0]   rd_reg_id,
    output logic [NUM_READ*ROB_WIDTH-1:0]   rob_rob_id,
    input  logic [NUM_READ-1:0]             rob_ready,
    input  logic [NUM_READ*XLEN-1:0]        rob_data,
    output logic [NUM_READ*XLEN-1:0]        rd_data,
    output logic [NUM_READ-1:0]             rd_pending,
    output logic [NUM_READ*ROB_WIDTH-1:0]   rd_dependency
);

    localparam int REG_SIZE = 2 ** REG_WIDTH;

    logic [REG_SIZE-1:0][XLEN-1:0]      r_data;
    logic [REG_SIZE-1:0]                r_pending;
    logic [REG_SIZE-1:0][ROB_WIDTH-1:0] r_dep;

    logic [REG_WIDTH-1:0] w_cm_reg  [NUM_COMMIT];
    logic [XLEN-1:0]      w_cm_data [NUM_COMMIT];
    logic [ROB_WIDTH-1:0] w_cm_rob  [NUM_COMMIT];

    for (genvar i = 0; i < NUM_COMMIT; i++) begin : g_commit_unpack
        assign w_cm_reg[i]  = commit_reg_id[i*REG_WIDTH +: REG_WIDTH];
        assign w_cm_data[i] = commit_data[i*XLEN +: XLEN];
        assign w_cm_rob[i]  = commit_rob_id[i*ROB_WIDTH +: ROB_WIDTH];
    end

    // Commits apply oldest-first so the highest port decides both data and
    // the pending clear; flush and issue are applied last and override them.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_data    <= '0;
            r_pending <= '0;
            r_dep     <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < NUM_COMMIT; i++) begin
                if (commit_en[i] && (w_cm_reg[i] != '0)) begin
                    r_data[w_cm_reg[i]]    <= w_cm_data[i];
                    r_pending[w_cm_reg[i]] <= r_pending[w_cm_reg[i]] &&
                                              (r_dep[w_cm_reg[i]] != w_cm_rob[i]);
                end
            end
            if (flush) begin
                r_pending <= '0;
            end else if (issue_en && (issue_reg_id != '0)) begin
                r_pending[issue_reg_id] <= 1'b1;
                r_dep[issue_reg_id]     <= issue_rob_id;
            end
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        logic [REG_WIDTH-1:0] w_rd_reg;
        logic                 w_byp_hit;
        logic [XLEN-1:0]      w_byp_data;

        assign w_rd_reg = rd_reg_id[p*REG_WIDTH +: REG_WIDTH];
        assign rob_rob_id[p*ROB_WIDTH +: ROB_WIDTH] = r_dep[w_rd_reg];

        always_comb begin
            w_byp_hit  = 1'b0;
            w_byp_data = '0;
            for (int i = 0; i < NUM_COMMIT; i++) begin
                if (commit_en[i] && (w_cm_reg[i] == w_rd_reg) && r_pending[w_rd_reg] &&
                    (w_cm_rob[i] == r_dep[w_rd_reg])) begin
                    w_byp_hit  = 1'b1;
                    w_byp_data = w_cm_data[i];
                end
            end
        end

        reg_read_port #(
            .XLEN      (XLEN),
            .REG_WIDTH (REG_WIDTH),
            .ROB_WIDTH (ROB_WIDTH)
        ) u_read_port (
            .i_reg_id        (w_rd_reg),
            .i_reg_data      (r_data[w_rd_reg]),
            .i_reg_pending   (r_pending[w_rd_reg]),
            .i_reg_dep       (r_dep[w_rd_reg]),
            .i_byp_hit       (w_byp_hit),
            .i_byp_data      (w_byp_data),
            .i_rob_ready     (rob_ready[p]),
            .i_rob_data      (rob_data[p*XLEN +: XLEN]),
            .o_rd_data       (rd_data[p*XLEN +: XLEN]),
            .o_rd_pending    (rd_pending[p]),
            .o_rd_dependency (rd_dependency[p*ROB_WIDTH +: ROB_WIDTH])
        );
    end

endmodule
`default_nettype wire
